// File: rtl/axi_pkg.sv
// Shared AXI definitions for the line master: FSM state type, burst and
// response encodings, and the AxSIZE helper.
package axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_RSP
    } axi_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE encoding for a bus of bus_w bits: log2 of the bytes per beat.
    function automatic logic [2:0] size_of(input int bus_w);
        return 3'($clog2(bus_w / 8));
    endfunction

endpackage

// File: rtl/axi_line_master_if.sv
// AXI4 channel bundle between the line master and the interconnect.
//
// Handshake rule on every channel: a transfer happens on a rising clock
// edge where valid and ready are both high; the source holds valid and its
// payload stable until that edge, and ready may change freely.
interface axi_line_master_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;

    logic [BUS_W-1:0]   wdata;
    logic [BUS_W/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [ID_W-1:0]    bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;

    logic [ID_W-1:0]    rid;
    logic [BUS_W-1:0]   rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_beat_shifter.sv
// Line register shared by both directions: loaded whole on request
// acceptance, written one bus-wide slot at a time by read beats, and read
// one slot at a time to feed write beats. line_next_o exposes the value the
// register takes at the next edge so the final read beat can be captured.
module axi_beat_shifter #(
    parameter int BUS_W  = 32,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] load_data_i,
    input  logic              wr_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [BUS_W-1:0]  wr_data_i,
    output logic [BUS_W-1:0]  slot_o,
    output logic [LINE_W-1:0] line_next_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Next line value: whole-line load wins over a single-slot write.
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_data_i;
        end else if (wr_i) begin
            line_d[int'(idx_i)*BUS_W +: BUS_W] = wr_data_i;
        end
    end

    // Pure data storage, no reset needed.
    always_ff @(posedge clk_i) begin
        line_q <= line_d;
    end

    assign slot_o      = line_q[int'(idx_i)*BUS_W +: BUS_W];
    assign line_next_o = line_d;

endmodule

// File: rtl/axi_line_master.sv
// AXI4 master turning cache-line or single-word requests into INCR bursts,
// one transaction in flight, with sticky error reporting on completion.
module axi_line_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32,
    parameter int LINE_W = 128,
    parameter int ID_W   = 4,
    parameter int ID_VAL = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic               req_single_i,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [LINE_W-1:0]  req_wdata_i,
    input  logic [BUS_W/8-1:0] req_wstrb_i,
    output logic               rsp_valid_o,
    output logic [LINE_W-1:0]  rsp_rdata_o,
    output logic               rsp_err_o,
    output axi_state_e         dbg_state_o,
    axi_line_master_if.master  m
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BUS_W / 8 - 1);
    localparam logic [7:0]        LINE_LEN  = 8'(BEATS - 1);
    localparam logic [ID_W-1:0]   ID        = ID_W'(ID_VAL);

    axi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   beat_q;
    logic               single_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         len_q;
    logic [BUS_W/8-1:0] strb_q;
    logic               err_q;
    logic [LINE_W-1:0]  rdata_q;

    logic req_ready, ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid;
    logic accept, r_fire, w_fire, b_fire, last_beat;
    logic [BUS_W-1:0]  w_slot;
    logic [LINE_W-1:0] line_next;
    logic [LINE_W-1:0] load_data;

    assign accept    = req_ready && req_valid_i;
    assign r_fire    = r_ready && m.rvalid;
    assign w_fire    = w_valid && m.wready;
    assign b_fire    = b_ready && m.bvalid;
    assign last_beat = (8'(beat_q) == len_q);
    assign load_data = req_we_i ? req_wdata_i : '0;

    axi_beat_shifter #(
        .BUS_W  (BUS_W),
        .LINE_W (LINE_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk_i       (clk_i),
        .load_i      (accept),
        .load_data_i (load_data),
        .wr_i        (r_fire),
        .idx_i       (beat_q),
        .wr_data_i   (m.rdata),
        .slot_o      (w_slot),
        .line_next_o (line_next)
    );

    // State register; reset abandons any transfer and returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and Moore outputs; everything stays low while in reset.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        rsp_valid = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid_i) state_d = req_we_i ? S_AW : S_AR;
                end
                S_AR: begin
                    ar_valid = 1'b1;
                    if (m.arready) state_d = S_R;
                end
                S_R: begin
                    r_ready = 1'b1;
                    if (m.rvalid && last_beat) state_d = S_RSP;
                end
                S_AW: begin
                    aw_valid = 1'b1;
                    if (m.awready) state_d = S_W;
                end
                S_W: begin
                    w_valid = 1'b1;
                    if (m.wready && last_beat) state_d = S_B;
                end
                S_B: begin
                    b_ready = 1'b1;
                    if (m.bvalid) state_d = S_RSP;
                end
                S_RSP: begin
                    rsp_valid = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Request capture, beat counter, sticky error flag and read result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_q   <= '0;
            single_q <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            strb_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                single_q <= req_single_i;
                addr_q   <= req_addr_i & (req_single_i ? WORD_MASK : LINE_MASK);
                len_q    <= req_single_i ? 8'd0 : LINE_LEN;
                strb_q   <= req_wstrb_i;
                err_q    <= 1'b0;
                beat_q   <= '0;
            end
            if (r_fire) begin
                beat_q <= beat_q + CNT_W'(1);
                if (m.rresp != RESP_OKAY || m.rid != ID || m.rlast != last_beat) err_q <= 1'b1;
                if (last_beat) rdata_q <= line_next;
            end
            if (w_fire) beat_q <= beat_q + CNT_W'(1);
            if (b_fire && (m.bresp != RESP_OKAY || m.bid != ID)) err_q <= 1'b1;
        end
    end

    assign req_ready_o = req_ready;
    assign rsp_valid_o = rsp_valid;
    assign rsp_err_o   = rsp_valid && err_q;
    assign rsp_rdata_o = rdata_q;
    assign dbg_state_o = state_q;

    assign m.awid    = ID;
    assign m.awaddr  = addr_q;
    assign m.awlen   = len_q;
    assign m.awsize  = size_of(BUS_W);
    assign m.awburst = BURST_INCR;
    assign m.awvalid = aw_valid;
    assign m.wdata   = w_slot;
    assign m.wstrb   = single_q ? strb_q : '1;
    assign m.wlast   = last_beat;
    assign m.wvalid  = w_valid;
    assign m.bready  = b_ready;
    assign m.arid    = ID;
    assign m.araddr  = addr_q;
    assign m.arlen   = len_q;
    assign m.arsize  = size_of(BUS_W);
    assign m.arburst = BURST_INCR;
    assign m.arvalid = ar_valid;
    assign m.rready  = r_ready;

endmodule

// File: tb/tb_axi_line_master.sv
// Testbench for axi_line_master: directed scenarios followed by random
// transactions, with an AXI slave played cycle by cycle from the stimulus
// process and a line-level reference model for addresses, data and errors.
module tb_axi_line_master;
    import axi_pkg::*;

    localparam int ADDR_W = 32;
    localparam int BUS_W  = 32;
    localparam int LINE_W = 128;
    localparam int ID_W   = 4;
    localparam int ID_VAL = 0;
    localparam int BEATS  = LINE_W / BUS_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               req_valid, req_ready, req_we, req_single;
    logic [ADDR_W-1:0]  req_addr;
    logic [LINE_W-1:0]  req_wdata;
    logic [BUS_W/8-1:0] req_wstrb;
    logic               rsp_valid, rsp_err;
    logic [LINE_W-1:0]  rsp_rdata;
    axi_state_e         dbg_state;

    axi_line_master_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .ID_W(ID_W)) bus ();

    axi_line_master #(
        .ADDR_W(ADDR_W), .BUS_W(BUS_W), .LINE_W(LINE_W), .ID_W(ID_W), .ID_VAL(ID_VAL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_single_i (req_single),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .dbg_state_o  (dbg_state),
        .m            (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [BUS_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input int bytes);
        return a - (a % ADDR_W'(bytes));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid  = 1'b0; bus.bid = '0; bus.bresp = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    endtask

    task automatic issue(input logic we, input logic single, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wdata, input logic [BUS_W/8-1:0] strb);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_single = single;
        req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic after_rsp();
        slave_idle();
        @(negedge clk);
        check("rsp_one_pulse", rsp_valid, 1'b0);
        check("ready_after_rsp", req_ready, 1'b1);
    endtask

    // Read: bad_resp_beat / bad_last_beat < 0 disable that fault.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic single, input logic [LINE_W-1:0] data,
                           input int bad_resp_beat, input int bad_last_beat, input logic bad_id,
                           input int ar_delay, input logic r_gaps, input int exp_cycle);
        int n, cyc, k, ar_cnt;
        logic ar_seen, done, fire, exp_err;
        logic [LINE_W-1:0] mask, exp_line;
        n = single ? 1 : BEATS;
        exp_err = bad_id || (bad_resp_beat >= 0 && bad_resp_beat < n) ||
                  (bad_last_beat >= 0 && bad_last_beat < n);
        mask = '0;
        for (int i = 0; i < n; i++) mask[i*BUS_W +: BUS_W] = '1;
        exp_line = data & mask;
        issue(1'b0, single, addr, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
        cyc = 2; k = 0; ar_cnt = 0; ar_seen = 1'b0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (rsp_valid) begin
                done = 1'b1;
                if (exp_cycle > 0) check("rd_latency", cyc, exp_cycle);
                check("rd_data", rsp_rdata & mask, exp_line);
                check("rd_err", rsp_err, exp_err);
                check("rd_beats", k, n);
            end else begin
                slave_idle();
                if (bus.arvalid) begin
                    if (!ar_seen) begin
                        check("araddr", bus.araddr, align(addr, single ? BUS_W/8 : LINE_W/8));
                        check("arlen", bus.arlen, n - 1);
                        check("arsize", bus.arsize, $clog2(BUS_W/8));
                        check("arburst", bus.arburst, 2'b01);
                        check("arid", bus.arid, ID_VAL);
                    end
                    ar_seen = 1'b1;
                    bus.arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end
                if (bus.rready && (!r_gaps || $urandom_range(0, 2) != 0)) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = (k < BEATS) ? data[k*BUS_W +: BUS_W] : '0;
                    bus.rlast  = (k == n - 1) ^ (k == bad_last_beat);
                    bus.rresp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
                    bus.rid    = bad_id ? ID_W'(ID_VAL + 1) : ID_W'(ID_VAL);
                end
                fire = bus.rvalid && bus.rready;
                @(posedge clk);
                if (fire) k++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check("rd_timeout", rsp_valid, 1'b1);
        after_rsp();
    endtask

    // Write: rst_after >= 0 pulls reset once that many W beats are accepted.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic single, input logic [LINE_W-1:0] data,
                            input logic [BUS_W/8-1:0] strb, input int aw_delay, input logic w_toggle,
                            input logic bad_bid, input logic bad_bresp, input int rst_after, input int exp_cycle);
        int n, cyc, got, aw_cnt;
        logic aw_seen, aw_done, done, tog, fire_aw, fire_w;
        logic [BUS_W-1:0]   beat;
        logic [BUS_W/8-1:0] exp_strb;
        n = single ? 1 : BEATS;
        exp_strb = single ? strb : '1;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(data[i*BUS_W +: BUS_W]);
        issue(1'b1, single, addr, data, strb);
        cyc = 2; got = 0; aw_cnt = 0; aw_seen = 1'b0; aw_done = 1'b0; done = 1'b0; tog = 1'b0;
        while (!done && cyc < 200) begin
            if (rsp_valid) begin
                done = 1'b1;
                if (exp_cycle > 0) check("wr_latency", cyc, exp_cycle);
                check("wr_err", rsp_err, bad_bid || bad_bresp);
                check("wr_beats", got, n);
            end else begin
                slave_idle();
                if (!aw_done) check("no_w_before_aw", bus.wvalid, 1'b0);
                if (bus.awvalid) begin
                    if (!aw_seen) begin
                        check("awaddr", bus.awaddr, align(addr, single ? BUS_W/8 : LINE_W/8));
                        check("awlen", bus.awlen, n - 1);
                        check("awsize", bus.awsize, $clog2(BUS_W/8));
                        check("awburst", bus.awburst, 2'b01);
                        check("awid", bus.awid, ID_VAL);
                    end
                    aw_seen = 1'b1;
                    bus.awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                end
                if (bus.wvalid) begin
                    tog = ~tog;
                    bus.wready = w_toggle ? tog : 1'b1;
                end
                // bvalid is offered early on purpose: it must be ignored until B.
                if (aw_done) begin
                    bus.bvalid = 1'b1;
                    bus.bid    = bad_bid ? ID_W'(ID_VAL + 1) : ID_W'(ID_VAL);
                    bus.bresp  = bad_bresp ? 2'b10 : 2'b00;
                end
                fire_aw = bus.awvalid && bus.awready;
                fire_w  = bus.wvalid && bus.wready;
                if (fire_w) begin
                    if (exp_q.size() == 0) begin
                        check("wr_extra_beat", bus.wvalid, 1'b0);
                    end else begin
                        beat = exp_q.pop_front();
                        check("wdata", bus.wdata, beat);
                        check("wstrb", bus.wstrb, exp_strb);
                        check("wlast", bus.wlast, exp_q.size() == 0);
                    end
                    got++;
                end
                @(posedge clk);
                if (fire_aw) aw_done = 1'b1;
                @(negedge clk);
                cyc++;
                if (rst_after >= 0 && got == rst_after) begin
                    rst_n = 1'b0;
                    slave_idle();
                    @(posedge clk);
                    @(negedge clk);
                    check("rst_awvalid", bus.awvalid, 1'b0);
                    check("rst_wvalid", bus.wvalid, 1'b0);
                    check("rst_arvalid", bus.arvalid, 1'b0);
                    check("rst_bready", bus.bready, 1'b0);
                    check("rst_rready", bus.rready, 1'b0);
                    check("rst_rsp_valid", rsp_valid, 1'b0);
                    check("rst_req_ready", req_ready, 1'b0);
                    rst_n = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        check("no_rsp_after_rst", rsp_valid, 1'b0);
                    end
                    check("ready_after_rst", req_ready, 1'b1);
                    exp_q.delete();
                    return;
                end
            end
        end
        if (!done) check("wr_timeout", rsp_valid, 1'b1);
        after_rsp();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [LINE_W-1:0] d;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_single = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        slave_idle();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_arvalid", bus.arvalid, 1'b0);
        check("reset_awvalid", bus.awvalid, 1'b0);
        check("reset_wvalid", bus.wvalid, 1'b0);
        check("reset_bready", bus.bready, 1'b0);
        check("reset_rready", bus.rready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);

        // 1: line read, rsp on cycle 3+BEATS counting the acceptance cycle as 1
        do_read(32'h1004, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0, -1, -1, 1'b0, 0, 1'b0, 3 + BEATS);

        // 2: line write, awready after 3 cycles, toggling wready
        do_write(32'h3008, 1'b0, 128'h00000044_00000033_00000022_00000011, 4'hF, 3, 1'b1, 1'b0, 1'b0, -1, -1);

        // 3: word write with partial strobe, earliest completion 4+1
        do_write(32'h2003, 1'b1, {96'd0, 32'hDEADBEEF}, 4'b0110, 0, 1'b0, 1'b0, 1'b0, -1, 5);

        // word read, earliest completion 3+1
        do_read(32'h4006, 1'b1, {96'd0, 32'h12345678}, -1, -1, 1'b0, 0, 1'b0, 4);

        // 4: error resp on beat 2, then early rlast on beat 1
        d = {$urandom, $urandom, $urandom, $urandom};
        do_read(32'h5010, 1'b0, d, 2, -1, 1'b0, 0, 1'b0, -1);
        d = {$urandom, $urandom, $urandom, $urandom};
        do_read(32'h5020, 1'b0, d, -1, 1, 1'b0, 1, 1'b1, -1);

        // 5: wrong bid
        do_write(32'h6000, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 0, 1'b0, 1'b1, 1'b0, -1, -1);

        // 6: reset in W after 2 beats, then a clean read
        do_write(32'h7000, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 0, 1'b0, 1'b0, 1'b0, 2, -1);
        do_read(32'h7040, 1'b0, {$urandom, $urandom, $urandom, $urandom}, -1, -1, 1'b0, 0, 1'b0, 3 + BEATS);

        // random traffic
        for (int t = 0; t < 24; t++) begin
            logic we, single;
            logic [ADDR_W-1:0] a;
            int bad_r, bad_l;
            we     = 1'($urandom_range(0, 1));
            single = 1'($urandom_range(0, 1));
            a      = $urandom;
            d      = {$urandom, $urandom, $urandom, $urandom};
            if (we) begin
                do_write(a, single, d, 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, -1, -1);
            end else begin
                bad_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
                bad_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
                do_read(a, single, d, bad_r, bad_l, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
            end
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
